// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM PIN entry block.
// Digits are BCD, digit 0 sits in the least significant nibble of a PIN.
package atm_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CHECK = 2'd1,
    GRANT = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int PIN_W      = NUM_DIGITS * BCD_W;

  // BCD increment that rolls 9 back to 0, so a digit never leaves 0..9.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= 4'd9) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pin_entry_if.sv
// Front-panel bundle between the button/PIN source and pin_entry.
// Buttons are debounced pulses that may stay high for many cycles; no
// valid/ready handshake exists: pin_ok/pin_fail are one-cycle pulses, and
// granted/locked are levels.
interface pin_entry_if;
  import atm_pkg::*;

  logic             btn_inc;
  logic             btn_next;
  logic             btn_enter;
  logic             btn_cancel;
  logic [PIN_W-1:0] stored_pin;
  logic [PIN_W-1:0] entered_pin;
  logic [1:0]       digit_idx;
  logic [1:0]       attempts_left;
  logic             granted;
  logic             locked;
  logic             pin_ok;
  logic             pin_fail;
  state_t           dbg_state;

  modport master (
    output btn_inc, btn_next, btn_enter, btn_cancel, stored_pin,
    input  entered_pin, digit_idx, attempts_left, granted, locked,
           pin_ok, pin_fail, dbg_state
  );

  modport slave (
    input  btn_inc, btn_next, btn_enter, btn_cancel, stored_pin,
    output entered_pin, digit_idx, attempts_left, granted, locked,
           pin_ok, pin_fail, dbg_state
  );

endinterface

// File: rtl/btn_edge.sv
// Two-flop register of a long debounced pulse plus a one-cycle rising-edge strobe.
// Both flops reset to 1 so a button held through reset never strobes.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic strobe
);

  logic q1_q, q1_d;
  logic q2_q, q2_d;

  always_comb begin
    q1_d = din;
    q2_d = q1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_q <= 1'b1;
      q2_q <= 1'b1;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign strobe = q1_q & ~q2_q;

endmodule

// File: rtl/pin_entry.sv
// PIN entry session controller: builds a BCD PIN from button strobes, checks
// it against the stored PIN, grants a session or locks out after repeated failures.
module pin_entry
  import atm_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 400_000_000
) (
  input logic         clk,
  input logic         rst,
  pin_entry_if.slave  bus
);

  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [1:0]       ATT_MAX  = 2'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

  state_t           state_q, state_d;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       att_q, att_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             granted_q, granted_d;
  logic             locked_q, locked_d;
  logic             ok_q, ok_d;
  logic             fail_q, fail_d;
  logic [1:0]       att_dec;

  logic s_inc, s_next, s_enter, s_cancel;

  btn_edge u_inc    (.clk(clk), .rst(rst), .din(bus.btn_inc),    .strobe(s_inc));
  btn_edge u_next   (.clk(clk), .rst(rst), .din(bus.btn_next),   .strobe(s_next));
  btn_edge u_enter  (.clk(clk), .rst(rst), .din(bus.btn_enter),  .strobe(s_enter));
  btn_edge u_cancel (.clk(clk), .rst(rst), .din(bus.btn_cancel), .strobe(s_cancel));

  assign att_dec = (att_q == 2'd0) ? 2'd0 : att_q - 2'd1;

  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    idx_d   = idx_q;
    att_d   = att_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      // if/else chain enforces cancel > enter > next > inc
      ENTRY: begin
        if (s_cancel) begin
          pin_d = '0;
          idx_d = '0;
        end else if (s_enter) begin
          state_d = CHECK;
        end else if (s_next) begin
          idx_d = idx_q + 2'd1;
        end else if (s_inc) begin
          pin_d[idx_q*BCD_W +: BCD_W] = bcd_inc(pin_q[idx_q*BCD_W +: BCD_W]);
        end
      end
      CHECK: begin
        if (pin_q == bus.stored_pin) begin
          ok_d    = 1'b1;
          att_d   = ATT_MAX;
          state_d = GRANT;
        end else begin
          fail_d = 1'b1;
          att_d  = att_dec;
          pin_d  = '0;
          idx_d  = '0;
          if (att_dec == 2'd0) begin
            state_d = LOCK;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ENTRY;
          end
        end
      end
      GRANT: begin
        if (s_cancel) begin
          pin_d   = '0;
          idx_d   = '0;
          state_d = ENTRY;
        end
      end
      LOCK: begin
        if (cnt_q == '0) begin
          att_d   = ATT_MAX;
          state_d = ENTRY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ENTRY;
    endcase
    granted_d = (state_d == GRANT);
    locked_d  = (state_d == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ENTRY;
      pin_q     <= '0;
      idx_q     <= '0;
      att_q     <= ATT_MAX;
      cnt_q     <= '0;
      granted_q <= 1'b0;
      locked_q  <= 1'b0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      idx_q     <= idx_d;
      att_q     <= att_d;
      cnt_q     <= cnt_d;
      granted_q <= granted_d;
      locked_q  <= locked_d;
      ok_q      <= ok_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.entered_pin   = pin_q;
  assign bus.digit_idx     = idx_q;
  assign bus.attempts_left = att_q;
  assign bus.granted       = granted_q;
  assign bus.locked        = locked_q;
  assign bus.pin_ok        = ok_q;
  assign bus.pin_fail      = fail_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry: table-driven entry/wrap vectors plus
// hand-written priority, held-button, lockout and reset-mid-lock sequences.
module tb_pin_entry;
  import atm_pkg::*;

  logic clk;
  logic rst;

  pin_entry_if bus ();

  pin_entry #(.MAX_ATTEMPTS(3), .LOCK_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitors ----------------
  int ok_cnt   = 0;
  int fail_cnt = 0;
  int lock_cyc = 0;
  logic [1:0] fail_att_q[$];

  always @(negedge clk) begin
    if (bus.pin_ok)   ok_cnt   <= ok_cnt + 1;
    if (bus.locked)   lock_cyc <= lock_cyc + 1;
    if (bus.pin_fail) begin
      fail_cnt <= fail_cnt + 1;
      fail_att_q.push_back(bus.attempts_left);
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // mask bits: [0] inc, [1] next, [2] enter, [3] cancel
  task automatic press(input logic [3:0] m, input int hold);
    @(negedge clk);
    bus.btn_inc    = m[0];
    bus.btn_next   = m[1];
    bus.btn_enter  = m[2];
    bus.btn_cancel = m[3];
    repeat (hold) @(negedge clk);
    bus.btn_inc    = 1'b0;
    bus.btn_next   = 1'b0;
    bus.btn_enter  = 1'b0;
    bus.btn_cancel = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic enter_digits(input logic [15:0] p);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] v;
      v = p[d*4 +: 4];
      for (int k = 0; k < int'(v); k++) press(4'b0001, 50);
      if (d < 3) press(4'b0010, 50);
    end
  endtask

  // Holds enter until locked rises; returns with enter still high.
  task automatic enter_until_locked(input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.btn_enter = 1'b1;
    while (!bus.locked && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_lock_rise"}, {31'd0, bus.locked}, 32'd1);
    check({tag, "_att_zero"}, {30'd0, bus.attempts_left}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  mask;
    int          reps;
    logic [15:0] pin;
    logic [1:0]  idx;
    logic [1:0]  att;
    logic        gr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int ok0, fail0, lk0, waited;

    vecs[0]  = '{4'b0001, 4, 16'h0004, 2'd0, 2'd3, 1'b0};
    vecs[1]  = '{4'b0010, 1, 16'h0004, 2'd1, 2'd3, 1'b0};
    vecs[2]  = '{4'b0001, 3, 16'h0034, 2'd1, 2'd3, 1'b0};
    vecs[3]  = '{4'b0010, 1, 16'h0034, 2'd2, 2'd3, 1'b0};
    vecs[4]  = '{4'b0001, 2, 16'h0234, 2'd2, 2'd3, 1'b0};
    vecs[5]  = '{4'b0010, 1, 16'h0234, 2'd3, 2'd3, 1'b0};
    vecs[6]  = '{4'b0001, 1, 16'h1234, 2'd3, 2'd3, 1'b0};
    vecs[7]  = '{4'b0100, 1, 16'h1234, 2'd3, 2'd3, 1'b1};
    vecs[8]  = '{4'b0001, 1, 16'h1234, 2'd3, 2'd3, 1'b1};
    vecs[9]  = '{4'b0010, 1, 16'h1234, 2'd3, 2'd3, 1'b1};
    vecs[10] = '{4'b0100, 1, 16'h1234, 2'd3, 2'd3, 1'b1};
    vecs[11] = '{4'b1000, 1, 16'h0000, 2'd0, 2'd3, 1'b0};
    vecs[12] = '{4'b0001, 9, 16'h0009, 2'd0, 2'd3, 1'b0};
    vecs[13] = '{4'b0001, 1, 16'h0000, 2'd0, 2'd3, 1'b0};
    vecs[14] = '{4'b0010, 3, 16'h0000, 2'd3, 2'd3, 1'b0};
    vecs[15] = '{4'b0010, 1, 16'h0000, 2'd0, 2'd3, 1'b0};

    rst            = 1'b1;
    bus.btn_inc    = 1'b0;
    bus.btn_next   = 1'b0;
    bus.btn_enter  = 1'b0;
    bus.btn_cancel = 1'b0;
    bus.stored_pin = 16'h1234;
    repeat (5) @(negedge clk);

    // reset state
    check("rst_pin", {16'd0, bus.entered_pin}, 32'd0);
    check("rst_idx", {30'd0, bus.digit_idx}, 32'd0);
    check("rst_att", {30'd0, bus.attempts_left}, 32'd3);
    check("rst_granted", {31'd0, bus.granted}, 32'd0);
    check("rst_locked", {31'd0, bus.locked}, 32'd0);
    check("rst_ok", {31'd0, bus.pin_ok}, 32'd0);
    check("rst_fail", {31'd0, bus.pin_fail}, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ENTRY));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // correct entry, grant behaviour, digit and index wrap
    ok0 = ok_cnt;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].mask, 50);
      check($sformatf("vec%0d_pin", i), {16'd0, bus.entered_pin}, {16'd0, vecs[i].pin});
      check($sformatf("vec%0d_idx", i), {30'd0, bus.digit_idx}, {30'd0, vecs[i].idx});
      check($sformatf("vec%0d_att", i), {30'd0, bus.attempts_left}, {30'd0, vecs[i].att});
      check($sformatf("vec%0d_granted", i), {31'd0, bus.granted}, {31'd0, vecs[i].gr});
      check($sformatf("vec%0d_locked", i), {31'd0, bus.locked}, 32'd0);
    end
    check("entry_ok_pulses", ok_cnt - ok0, 32'd1);

    // priority: cancel beats inc
    press(4'b0001, 50);
    press(4'b0010, 50);
    press(4'b1001, 50);
    check("prio_cancel_pin", {16'd0, bus.entered_pin}, 32'd0);
    check("prio_cancel_idx", {30'd0, bus.digit_idx}, 32'd0);

    // priority: enter beats next (idx stays 3 through a matching check)
    enter_digits(16'h1234);
    check("prio_pre_pin", {16'd0, bus.entered_pin}, 32'h1234);
    ok0 = ok_cnt;
    press(4'b0110, 50);
    check("prio_enter_granted", {31'd0, bus.granted}, 32'd1);
    check("prio_enter_idx", {30'd0, bus.digit_idx}, 32'd3);
    check("prio_enter_ok", ok_cnt - ok0, 32'd1);
    press(4'b1000, 50);
    check("prio_cancel_state", 32'(bus.dbg_state), 32'(ENTRY));

    // held button: one increment for 1000 high cycles
    press(4'b0001, 1000);
    check("held_inc_pin", {16'd0, bus.entered_pin}, 32'h0001);
    press(4'b1000, 50);

    // inc held across reset release: no increment
    @(negedge clk);
    bus.btn_inc = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("held_rst_pin", {16'd0, bus.entered_pin}, 32'd0);
    bus.btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    check("held_rst_release_pin", {16'd0, bus.entered_pin}, 32'd0);

    // lockout: three wrong submissions
    fail0 = fail_cnt;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    press(4'b0100, 50);
    check("lock_att_after1", {30'd0, bus.attempts_left}, 32'd2);
    check("lock_granted_after1", {31'd0, bus.granted}, 32'd0);
    press(4'b0100, 50);
    check("lock_att_after2", {30'd0, bus.attempts_left}, 32'd1);
    lk0 = lock_cyc;
    enter_until_locked("lock1");
    bus.btn_enter = 1'b0;
    // buttons during lockout must change nothing
    repeat (2) @(negedge clk);
    bus.btn_cancel = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_cancel = 1'b0;
    bus.btn_next = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_next = 1'b0;
    bus.btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_inc = 1'b0;
    waited = 0;
    while (bus.locked && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("lock_fall", {31'd0, bus.locked}, 32'd0);
    @(negedge clk);
    check("lock_cycles", lock_cyc - lk0, 32'd16);
    check("lock_fail_pulses", fail_cnt - fail0, 32'd3);
    check("lock_after_state", 32'(bus.dbg_state), 32'(ENTRY));
    check("lock_after_att", {30'd0, bus.attempts_left}, 32'd3);
    check("lock_after_pin", {16'd0, bus.entered_pin}, 32'd0);
    check("lock_after_idx", {30'd0, bus.digit_idx}, 32'd0);

    // reset 5 cycles into lockout clears it without a clock edge
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    press(4'b0100, 50);
    press(4'b0100, 50);
    enter_until_locked("lock2");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midlock_locked", {31'd0, bus.locked}, 32'd0);
    check("midlock_att", {30'd0, bus.attempts_left}, 32'd3);
    check("midlock_pin", {16'd0, bus.entered_pin}, 32'd0);
    check("midlock_state", 32'(bus.dbg_state), 32'(ENTRY));
    bus.btn_enter = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midlock_stays_unlocked", {31'd0, bus.locked}, 32'd0);

    // attempts_left reported alongside every pin_fail pulse
    check("fail_count", fail_att_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < fail_att_q.size())
        check($sformatf("fail_att%0d", i), {30'd0, fail_att_q[i]}, {30'd0, exp_q[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
